// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions: game command codes, scan codes and the
// frame receiver state type.
package ps2_pkg;

    localparam logic [1:0] CMD_UP    = 2'b00;
    localparam logic [1:0] CMD_LEFT  = 2'b01;
    localparam logic [1:0] CMD_RIGHT = 2'b10;
    localparam logic [1:0] CMD_ENTER = 2'b11;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK
    } frame_state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] cmd;
    } key_map_t;

    // Arrow keys only exist as E0-prefixed codes; enter only as a plain code.
    function automatic key_map_t map_key(input logic ext, input logic [7:0] code);
        key_map_t m;
        m.hit = 1'b1;
        m.cmd = CMD_UP;
        if (ext) begin
            case (code)
                SC_UP:    m.cmd = CMD_UP;
                SC_LEFT:  m.cmd = CMD_LEFT;
                SC_RIGHT: m.cmd = CMD_RIGHT;
                default:  m.hit = 1'b0;
            endcase
        end else if (code == SC_ENTER) begin
            m.cmd = CMD_ENTER;
        end else begin
            m.hit = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_rx_frame.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit frame
// deserializer with parity/stop check and a partial-frame timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       data_sync_q, data_sync_d;
    frame_state_t     state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       shift_q, shift_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             fall;
    logic             data_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tmo_q       <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
        end
    end

    assign fall      = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_s    = data_sync_q[1];
    assign byte_data = shift_q[7:0];

    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tmo_d       = tmo_q;
        byte_valid  = 1'b0;
        err         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (fall && !data_s) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (fall) begin
                    // Right shift: data bit 0 lands in [0], parity in [8], stop in [9].
                    shift_d = {data_s, shift_q[9:1]};
                    tmo_d   = '0;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ST_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    // err is registered in the top, so the strobe lands
                    // TIMEOUT_CYCLES cycles after the last fall.
                    if (tmo_d == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = ST_IDLE;
                        err     = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if ((^shift_q[8:0]) && shift_q[9]) begin
                    byte_valid = 1'b1;
                end else begin
                    err = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: turns E0/F0-prefixed scan codes for the four game
// keys into a registered 2-bit command strobe.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [1:0] cmd,
    output logic       cmd_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    key_map_t   key;

    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [1:0] cmd_q, cmd_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic       frame_err_q, frame_err_d;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_data (rx_byte),
        .byte_valid(rx_valid),
        .err       (rx_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            cmd_q       <= CMD_UP;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign key = map_key(ext_q, rx_byte);

    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;

        if (rx_err) begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                // Key releases (F0-prefixed) are swallowed.
                if (!brk_q && key.hit) begin
                    cmd_d       = key.cmd;
                    cmd_valid_d = 1'b1;
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign frame_err = frame_err_q;

endmodule
